note_highway_vga: RTL and testbench

Parametrised successor to the fixed four-lane note display. Generates 640x480 VGA timing on `vgaclk` and renders a scrolling note highway of `LANES` horizontal lanes and `SLOTS` beat slots. Note lines are fetched from an external note ROM over a valid/ready-style handshake into a one-entry prefetch buffer. All state is in the `vgaclk` domain; nothing is clocked from `vsync`.

---
 rtl/note_highway_vga.sv | 211 +++++++++++++++++++++
 tb/tb_note_highway_vga.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/note_highway_vga.sv
// note_highway_vga: VGA timing generator with a scrolling LANES x SLOTS note highway fed from a note ROM.
// Define HIT_LINE_EN to draw an orange hit line at columns HIT_COL..HIT_COL+3.
`timescale 1ns/1ps
module note_highway_vga #(
  parameter int LANES    = 4,
  parameter int SLOTS    = 4,
  parameter int SLOT_GAP = 160,
  parameter int NOTE_LEN = 150,
  parameter int SPEED    = 5,
  parameter int ROM_AW   = 8,
  parameter int HPIXELS  = 640,
  parameter int HFP      = 16,
  parameter int HPULSE   = 96,
  parameter int HBP      = 48,
  parameter int VLINES   = 480,
  parameter int VFP      = 10,
  parameter int VPULSE   = 2,
  parameter int VBP      = 33,
  parameter int HIT_COL  = 560
) (
  input  logic              vgaclk,
  input  logic              rst_n,
  input  logic              pause,
  output logic              note_req,
  output logic [ROM_AW-1:0] note_addr,
  input  logic              note_valid,
  input  logic [LANES-1:0]  note_data,
  output logic              hsync,
  output logic              vsync,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic [19:0]       frame_cnt,
  output logic              underrun
);
  localparam int CW = 11;
  localparam int PW = CW + 1;
  localparam logic [CW-1:0] H_LAST  = CW'(HPIXELS + HFP + HPULSE + HBP - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(VLINES + VFP + VPULSE + VBP - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(HPIXELS);
  localparam logic [CW-1:0] V_ACT   = CW'(VLINES);
  localparam logic [CW-1:0] HS_ON   = CW'(HPIXELS + HFP);
  localparam logic [CW-1:0] HS_OFF  = CW'(HPIXELS + HFP + HPULSE);
  localparam logic [CW-1:0] VS_ON   = CW'(VLINES + VFP);
  localparam logic [CW-1:0] VS_OFF  = CW'(VLINES + VFP + VPULSE);
  localparam logic [CW-1:0] LANE_H  = CW'(VLINES / LANES);
  localparam logic [PW-1:0] WRAP_AT = PW'(HPIXELS - 1 + NOTE_LEN);
  localparam logic [PW-1:0] P_LEN   = PW'(NOTE_LEN);
  localparam logic [PW-1:0] P_SPEED = PW'(SPEED);

  if (VLINES % LANES != 0 || HIT_COL < 0) begin : g_bad_cfg
    $error("VLINES must be divisible by LANES and HIT_COL must be non-negative");
  end

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t              r_state, w_state_nx;
  logic [CW-1:0]       r_hc, r_vc;
  logic [PW-1:0]       r_pos [SLOTS];
  logic [PW-1:0]       w_pos_nx [SLOTS];
  logic [LANES-1:0]    r_notes [SLOTS];
  logic [LANES-1:0]    w_notes_nx [SLOTS];
  logic [LANES-1:0]    r_buf;
  logic [ROM_AW-1:0]   r_addr;
  logic [19:0]         r_frame;
  logic                r_under, r_hs, r_vs;
  logic [11:0]         r_rgb, w_rgb;
  logic                w_upd, w_req, w_consume, w_under, w_note, w_head;
  logic [2:0]          w_lane;
  logic [PW-1:0]       w_hcp;

  function automatic logic [11:0] lane_rgb(input logic [2:0] k);
    case (k)
      3'd0, 3'd5: lane_rgb = 12'h0F0;
      3'd1, 3'd6: lane_rgb = 12'hF00;
      3'd2, 3'd7: lane_rgb = 12'hFF0;
      3'd3:       lane_rgb = 12'h00F;
      default:    lane_rgb = 12'hF80;
    endcase
  endfunction

  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (r_hc == H_LAST) begin
      r_hc <= '0;
      r_vc <= (r_vc == V_LAST) ? '0 : r_vc + 1'b1;
    end else begin
      r_hc <= r_hc + 1'b1;
    end
  end

  // Frame update fires in vertical blanking, so changes land on the next frame
  assign w_upd = (r_hc == '0) && (r_vc == V_ACT) && !pause;

  always_comb begin
    logic taken;
    taken      = 1'b0;
    w_consume  = 1'b0;
    w_under    = 1'b0;
    w_pos_nx   = r_pos;
    w_notes_nx = r_notes;
    for (int i = 0; i < SLOTS; i++) begin
      if (r_pos[i] >= WRAP_AT) begin
        w_pos_nx[i] = '0;
        if (!taken && r_state == S_FULL) begin
          w_notes_nx[i] = r_buf;
          w_consume     = 1'b1;
        end else begin
          w_notes_nx[i] = '0;
          w_under       = 1'b1;
        end
        taken = 1'b1;
      end else begin
        w_pos_nx[i] = r_pos[i] + P_SPEED;
      end
    end
  end

  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_req      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        w_req = 1'b1;
        if (note_valid) w_state_nx = S_FULL;
      end
      S_FULL: if (w_upd && w_consume) w_state_nx = S_EMPTY;
      default: w_state_nx = S_EMPTY;
    endcase
  end

  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf   <= '0;
      r_addr  <= '0;
      r_frame <= '0;
      r_under <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        r_pos[i]   <= PW'(i * SLOT_GAP);
        r_notes[i] <= '1;
      end
    end else begin
      if (w_req && note_valid) begin
        r_buf  <= note_data;
        r_addr <= r_addr + 1'b1;
      end
      if (w_upd) begin
        r_pos   <= w_pos_nx;
        r_notes <= w_notes_nx;
        r_frame <= r_frame + 1'b1;
        if (w_under) r_under <= 1'b1;
      end
    end
  end

  assign w_lane = 3'(r_vc / LANE_H);
  assign w_hcp  = {1'b0, r_hc};

  always_comb begin
    logic [PW-1:0]    lo;
    logic [LANES-1:0] sh;
    w_note = 1'b0;
    w_head = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      lo = (r_pos[i] < P_LEN) ? '0 : r_pos[i] - P_LEN;
      sh = r_notes[i] >> w_lane;
      if (lo < w_hcp && w_hcp < r_pos[i] && sh[0]) w_note = 1'b1;
      if (w_hcp == r_pos[i]) w_head = 1'b1;
    end
  end

  always_comb begin
    w_rgb = 12'hFFF;
    if (w_head) w_rgb = 12'h888;
    if (w_note) w_rgb = lane_rgb(w_lane);
`ifdef HIT_LINE_EN
    if (r_hc >= CW'(HIT_COL) && r_hc <= CW'(HIT_COL + 3)) w_rgb = 12'hF80;
`endif
    if (r_hc >= H_ACT || r_vc >= V_ACT) w_rgb = 12'h000;
  end

  // Colour and syncs share one register stage so they stay aligned
  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_rgb <= '0;
    end else begin
      r_hs  <= !(r_hc >= HS_ON && r_hc < HS_OFF);
      r_vs  <= !(r_vc >= VS_ON && r_vc < VS_OFF);
      r_rgb <= w_rgb;
    end
  end

  assign note_req  = w_req;
  assign note_addr = r_addr;
  assign hsync     = r_hs;
  assign vsync     = r_vs;
  assign red       = r_rgb[11:8];
  assign green     = r_rgb[7:4];
  assign blue      = r_rgb[3:0];
  assign frame_cnt = r_frame;
  assign underrun  = r_under;
endmodule

// File: tb/tb_note_highway_vga.sv
// Randomized scoreboard bench for note_highway_vga on a shrunken raster; a frame-level model predicts every output cycle.
`timescale 1ns/1ps
module tb_note_highway_vga;
  localparam int LANES = 6, SLOTS = 4, SLOT_GAP = 8, NOTE_LEN = 10, SPEED = 3, ROM_AW = 3;
  localparam int HP = 32, HFP = 2, HPU = 4, HBP = 2;
  localparam int VL = 24, VFP = 1, VPU = 2, VBP = 1;
  localparam int HIT_COL = 20;
  localparam int HTOT = HP + HFP + HPU + HBP;
  localparam int VTOT = VL + VFP + VPU + VBP;
  localparam int FRAME = HTOT * VTOT;

  logic vgaclk = 1'b0, rst_n = 1'b0, pause = 1'b0, note_valid = 1'b0;
  logic [LANES-1:0] note_data = '0;
  logic note_req, hsync, vsync, underrun;
  logic [ROM_AW-1:0] note_addr;
  logic [3:0] red, green, blue;
  logic [19:0] frame_cnt;

  note_highway_vga #(
    .LANES(LANES), .SLOTS(SLOTS), .SLOT_GAP(SLOT_GAP), .NOTE_LEN(NOTE_LEN), .SPEED(SPEED),
    .ROM_AW(ROM_AW), .HPIXELS(HP), .HFP(HFP), .HPULSE(HPU), .HBP(HBP),
    .VLINES(VL), .VFP(VFP), .VPULSE(VPU), .VBP(VBP), .HIT_COL(HIT_COL)
  ) dut (
    .vgaclk(vgaclk), .rst_n(rst_n), .pause(pause), .note_req(note_req), .note_addr(note_addr),
    .note_valid(note_valid), .note_data(note_data), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .frame_cnt(frame_cnt), .underrun(underrun)
  );

  always #5 vgaclk = ~vgaclk;

  typedef struct packed {
    logic hs; logic vs; logic [11:0] rgb; logic [19:0] fc; logic und; logic req; logic [ROM_AW-1:0] addr;
  } exp_t;
  exp_t q[$];
  exp_t m_e, got;

  int checks = 0, failures = 0;
  int m_t, m_pos[SLOTS], m_notes[SLOTS], m_fc, m_buf, m_addr;
  bit m_full, m_und;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    m_t = 0; m_fc = 0; m_buf = 0; m_addr = 0; m_full = 0; m_und = 0;
    for (int i = 0; i < SLOTS; i++) begin
      m_pos[i] = i * SLOT_GAP;
      m_notes[i] = (1 << LANES) - 1;
    end
  endtask

  function automatic logic [11:0] lane_col(input int k);
    case (k % 5)
      0: return 12'h0F0;
      1: return 12'hF00;
      2: return 12'hFF0;
      3: return 12'h00F;
      default: return 12'hF80;
    endcase
  endfunction

  function automatic logic [11:0] model_pix(input int hc, input int vc);
    int k, lo;
    if (hc >= HP || vc >= VL) return 12'h000;
`ifdef HIT_LINE_EN
    if (hc >= HIT_COL && hc <= HIT_COL + 3) return 12'hF80;
`endif
    k = vc / (VL / LANES);
    for (int i = 0; i < SLOTS; i++) begin
      lo = (m_pos[i] < NOTE_LEN) ? 0 : m_pos[i] - NOTE_LEN;
      if (lo < hc && hc < m_pos[i] && ((m_notes[i] >> k) & 1) == 1) return lane_col(k);
    end
    for (int i = 0; i < SLOTS; i++) if (hc == m_pos[i]) return 12'h888;
    return 12'hFFF;
  endfunction

  // Model: derive raster position from cycles since reset, predict the registered outputs after this edge
  always @(posedge vgaclk) begin
    if (!rst_n) begin
      m_reset();
      q.delete();
    end else begin
      int hc, vc;
      bit xfer, cons, taken;
      hc = m_t % HTOT;
      vc = (m_t / HTOT) % VTOT;
      m_e.hs  = !(hc >= HP + HFP && hc < HP + HFP + HPU);
      m_e.vs  = !(vc >= VL + VFP && vc < VL + VFP + VPU);
      m_e.rgb = model_pix(hc, vc);
      xfer = !m_full && note_valid;
      cons = 0;
      if (hc == 0 && vc == VL && !pause) begin
        m_fc = (m_fc + 1) % (1 << 20);
        taken = 0;
        for (int i = 0; i < SLOTS; i++) begin
          if (m_pos[i] >= HP - 1 + NOTE_LEN) begin
            m_pos[i] = 0;
            if (!taken && m_full) begin m_notes[i] = m_buf; cons = 1; end
            else begin m_notes[i] = 0; m_und = 1; end
            taken = 1;
          end else m_pos[i] += SPEED;
        end
      end
      if (xfer) begin
        m_buf = int'(note_data);
        m_addr = (m_addr + 1) % (1 << ROM_AW);
        m_full = 1;
      end else if (cons) m_full = 0;
      m_t++;
      m_e.fc = m_fc[19:0];
      m_e.und = m_und;
      m_e.req = !m_full;
      m_e.addr = m_addr[ROM_AW-1:0];
      q.push_back(m_e);
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
    chk({tag, "_frame"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_underrun"}, 32'(underrun), 32'd0);
    chk({tag, "_addr"}, 32'(note_addr), 32'd0);
    chk({tag, "_req"}, 32'(note_req), 32'd1);
  endtask

  // Monitor
  always @(posedge vgaclk) begin
    #2;
    if (!rst_n) check_reset("rst");
    else if (q.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty at %0t: got no expected entry, required one", $time);
    end else begin
      got = q.pop_front();
      chk("hsync", 32'(hsync), 32'(got.hs));
      chk("vsync", 32'(vsync), 32'(got.vs));
      chk("rgb", 32'({red, green, blue}), 32'(got.rgb));
      chk("frame_cnt", 32'(frame_cnt), 32'(got.fc));
      chk("underrun", 32'(underrun), 32'(got.und));
      chk("note_req", 32'(note_req), 32'(got.req));
      chk("note_addr", 32'(note_addr), 32'(got.addr));
    end
  end

  initial begin
    note_valid = 1'b1;
    note_data = LANES'(6'b000101);
    repeat (3) @(negedge vgaclk);
    rst_n = 1'b1;
    repeat (8 * FRAME) @(negedge vgaclk);
    for (int c = 0; c < 5 * FRAME; c++) begin
      @(negedge vgaclk);
      note_valid = ($urandom_range(0, 3) == 0);
      note_data = LANES'($urandom);
    end
    @(negedge vgaclk);
    #1 rst_n = 1'b0;
    #1 check_reset("async_rst");
    repeat (2) @(negedge vgaclk);
    note_valid = 1'b0;
    rst_n = 1'b1;
    repeat (8 * FRAME) @(negedge vgaclk);
    for (int c = 0; c < 4 * FRAME; c++) begin
      @(negedge vgaclk);
      pause = (c >= FRAME / 3);
      note_valid = ($urandom_range(0, 1) == 0);
      note_data = LANES'($urandom);
    end
    for (int f = 0; f < 8; f++) begin
      repeat ($urandom_range(1, FRAME - 1)) @(negedge vgaclk);
      pause = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < FRAME; c++) begin
        @(negedge vgaclk);
        note_valid = ($urandom_range(0, 7) == 0);
        note_data = LANES'($urandom);
      end
    end
    pause = 1'b0;
    repeat (3) @(negedge vgaclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
